bcd_display_scan: RTL

//  Downstream consumer of the 16-bit packed BCD word (4 nibbles: thousands..units) produced by the

---
 rtl/bcd_disp_pkg.sv | 25 ++
 rtl/bcd_to_7seg.sv | 32 +++
 rtl/bcd_display_scan.sv | 94 +++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the 4-digit BCD scan display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_GAP   = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-decimal nibbles render as a dash.
import bcd_disp_pkg::*;

module bcd_to_7seg (
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    if (blank) begin
      seg_n = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg_n = SEG_0;
        4'd1:    seg_n = SEG_1;
        4'd2:    seg_n = SEG_2;
        4'd3:    seg_n = SEG_3;
        4'd4:    seg_n = SEG_4;
        4'd5:    seg_n = SEG_5;
        4'd6:    seg_n = SEG_6;
        4'd7:    seg_n = SEG_7;
        4'd8:    seg_n = SEG_8;
        4'd9:    seg_n = SEG_9;
        default: seg_n = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 4-digit 7-segment scanner with leading-zero
// blanking and frame-synchronous (tear-free) value update.
import bcd_disp_pkg::*;

module bcd_display_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [15:0]           DATA_BCD_in,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic [6:0]            seg_n,
  output logic                  frame_start
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(REFRESH_DIV - 1);

  scan_state_t   state;
  logic [PW-1:0] prescaler;
  logic [1:0]    idx;
  logic [15:0]   pend_reg;
  logic [15:0]   disp_reg;
  logic          pending;

  logic        take_pend;
  logic [15:0] word_sel;
  logic [15:0] upper;
  logic [3:0]  nibble;
  logic        lz;
  logic [6:0]  seg_dec;

  // The GAP that opens a frame decodes the word about to be latched.
  always_comb begin
    take_pend = (state == ST_GAP) && (idx == 2'd0) && pending;
    word_sel  = take_pend ? pend_reg : disp_reg;
    upper     = word_sel >> {idx, 2'b00};
    nibble    = upper[3:0];
    lz        = blank_lz && (idx != 2'd0) && (upper == 16'h0);
  end

  bcd_to_7seg u_dec (
    .nibble (nibble),
    .blank  (lz),
    .seg_n  (seg_dec)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_GAP;
      prescaler   <= '0;
      idx         <= 2'd0;
      pend_reg    <= 16'h0;
      disp_reg    <= 16'h0;
      pending     <= 1'b0;
      anode_n     <= '1;
      seg_n       <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (load) begin
        pend_reg <= DATA_BCD_in;
        pending  <= 1'b1;
      end else if (take_pend) begin
        pending  <= 1'b0;
      end
      unique case (state)
        ST_GAP: begin
          state     <= ST_DRIVE;
          prescaler <= '0;
          anode_n   <= ~(4'b0001 << idx);
          seg_n     <= seg_dec;
          if (idx == 2'd0) frame_start <= 1'b1;
          if (take_pend) disp_reg <= pend_reg;
        end
        ST_DRIVE: begin
          prescaler <= prescaler + PW'(1);
          if (prescaler == PS_LAST) begin
            state   <= ST_GAP;
            idx     <= idx + 2'd1;
            anode_n <= '1;
            seg_n   <= SEG_BLANK;
          end else begin
            seg_n   <= seg_dec;
          end
        end
        default: state <= ST_GAP;
      endcase
    end
  end

endmodule
